drop_board_ctrl: RTL and testbench

//  Parametrised drop-token board for the LED-matrix Connect-Four game.

---
 rtl/drop_board_ctrl.sv | 153 +++++++++++++++
 tb/tb_drop_board_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_board_ctrl.sv
// Connect-Four drop board: per-column heights, per-cell owners, one-level undo,
// and registered red/green pixel planes for the 16x16 LED matrix.
module drop_board_ctrl #(
    parameter int COLS     = 8,
    parameter int ROWS     = 6,
    parameter int COL_OFS  = 4,
    parameter int ROW_BASE = 15,
    localparam int CW      = $clog2(COLS + 1),
    localparam int RW      = $clog2(ROWS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 drop_valid,
    input  logic [CW-1:0]        drop_col,
    input  logic                 player,
    output logic                 drop_ready,
    input  logic                 undo_valid,
    output logic                 move_ok,
    output logic                 move_rej,
    output logic                 undo_done,
    output logic                 last_valid,
    output logic [CW-1:0]        last_col,
    output logic [RW-1:0]        last_row,
    output logic [COLS*RW-1:0]   heights,
    output logic                 board_full,
    output logic [15:0][15:0]    redpixels,
    output logic [15:0][15:0]    grnpixels
);

    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {PLAY, FULL} state_t;

    state_t                     state_q, state_d;
    logic [COLS-1:0][ROWS-1:0]  occ_q, occ_d, own_q, own_d;
    logic [COLS-1:0][RW-1:0]    hgt_q, hgt_d;
    logic [CW-1:0]              lcol_q, lcol_d;
    logic [RW-1:0]              lrow_q, lrow_d;
    logic                       lvld_q, lvld_d;
    logic                       ok_q, ok_d, rej_q, rej_d, undo_q, undo_d;
    logic                       full_q, full_d;
    logic [15:0][15:0]          red_q, red_d, grn_q, grn_d;

    logic [CIW-1:0]             dc, lc;
    logic [RIW-1:0]             dr, lr;
    logic                       take, legal;
    logic [15:0]                sum;

    // Undo outranks a drop in the same cycle by withholding ready.
    assign drop_ready = (state_q == PLAY) && !undo_valid;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        own_d   = own_q;
        hgt_d   = hgt_q;
        lcol_d  = lcol_q;
        lrow_d  = lrow_q;
        lvld_d  = lvld_q;
        ok_d    = 1'b0;
        rej_d   = 1'b0;
        undo_d  = 1'b0;
        sum     = '0;
        dc      = drop_col[CIW-1:0];
        lc      = lcol_q[CIW-1:0];
        lr      = lrow_q[RIW-1:0];
        dr      = hgt_q[dc][RIW-1:0];
        take    = drop_valid && drop_ready;
        legal   = (drop_col < CW'(COLS)) && (hgt_q[dc] < RW'(ROWS));

        if (undo_valid && lvld_q) begin
            occ_d[lc][lr] = 1'b0;
            own_d[lc][lr] = 1'b0;
            hgt_d[lc]     = hgt_q[lc] - RW'(1);
            lvld_d        = 1'b0;
            undo_d        = 1'b1;
            state_d       = PLAY;
        end else if (take) begin
            if (legal) begin
                occ_d[dc][dr] = 1'b1;
                own_d[dc][dr] = player;
                hgt_d[dc]     = hgt_q[dc] + RW'(1);
                lcol_d        = drop_col;
                lrow_d        = hgt_q[dc];
                lvld_d        = 1'b1;
                ok_d          = 1'b1;
            end else begin
                rej_d = 1'b1;
            end
        end

        for (int c = 0; c < COLS; c++) sum = sum + 16'(hgt_d[c]);
        full_d = (sum == 16'(COLS * ROWS));
        if (ok_d && full_d) state_d = FULL;
    end

    // Pixel planes are built from the registered board, so they trail it by one edge.
    always_comb begin
        red_d = '0;
        grn_d = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                red_d[ROW_BASE-r][COL_OFS+c] = occ_q[c][r] && !own_q[c][r];
                grn_d[ROW_BASE-r][COL_OFS+c] = occ_q[c][r] &&  own_q[c][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            occ_q   <= '0;
            own_q   <= '0;
            hgt_q   <= '0;
            lcol_q  <= '0;
            lrow_q  <= '0;
            lvld_q  <= 1'b0;
            ok_q    <= 1'b0;
            rej_q   <= 1'b0;
            undo_q  <= 1'b0;
            full_q  <= 1'b0;
            red_q   <= '0;
            grn_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            own_q   <= own_d;
            hgt_q   <= hgt_d;
            lcol_q  <= lcol_d;
            lrow_q  <= lrow_d;
            lvld_q  <= lvld_d;
            ok_q    <= ok_d;
            rej_q   <= rej_d;
            undo_q  <= undo_d;
            full_q  <= full_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
        end
    end

    assign move_ok    = ok_q;
    assign move_rej   = rej_q;
    assign undo_done  = undo_q;
    assign last_valid = lvld_q;
    assign last_col   = lcol_q;
    assign last_row   = lrow_q;
    assign heights    = hgt_q;
    assign board_full = full_q;
    assign redpixels  = red_q;
    assign grnpixels  = grn_q;

endmodule

// File: tb/tb_drop_board_ctrl.sv
// Bench for drop_board_ctrl: directed scenarios plus a random run against a
// cell-array model of the board.
module tb_drop_board_ctrl;
    localparam int COLS = 8, ROWS = 6, COL_OFS = 4, ROW_BASE = 15;
    localparam int CW = 4, RW = 3, CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic reset = 1'b1, drop_valid = 1'b0, player = 1'b0, undo_valid = 1'b0;
    logic [CW-1:0] drop_col = '0;
    logic drop_ready, move_ok, move_rej, undo_done, last_valid, board_full;
    logic [CW-1:0] last_col;
    logic [RW-1:0] last_row;
    logic [COLS*RW-1:0] heights;
    logic [15:0][15:0] redpixels, grnpixels;

    drop_board_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_OFS(COL_OFS), .ROW_BASE(ROW_BASE)) dut (
        .clk(clk), .reset(reset), .drop_valid(drop_valid), .drop_col(drop_col),
        .player(player), .drop_ready(drop_ready), .undo_valid(undo_valid),
        .move_ok(move_ok), .move_rej(move_rej), .undo_done(undo_done),
        .last_valid(last_valid), .last_col(last_col), .last_row(last_row),
        .heights(heights), .board_full(board_full),
        .redpixels(redpixels), .grnpixels(grnpixels));

    always #5 clk = ~clk;

    int vec = 0, miss = 0;

    // Model: cell owner (-1 empty), column counts, undo record, expected pulses/pixels.
    int mc[COLS][ROWS];
    int mh[COLS];
    int ml_valid, ml_col, ml_row;
    bit e_ok, e_rej, e_undo;
    logic [15:0][15:0] er, eg;

    function automatic int total();
        int t = 0;
        for (int c = 0; c < COLS; c++) t += mh[c];
        return t;
    endfunction

    function automatic logic [COLS*RW-1:0] exp_h();
        logic [COLS*RW-1:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c*RW +: RW] = 3'(mh[c]);
        return v;
    endfunction

    function automatic int hcol(input int c);
        logic [COLS*RW-1:0] h = heights;
        return int'(h[c*RW +: RW]);
    endfunction

    task automatic drv(input bit dv, input int col, input bit pl, input bit uv);
        drop_valid = dv; drop_col = 4'(col); player = pl; undo_valid = uv;
        #1;
    endtask

    // One clock edge; the model follows the game rules on the same edge.
    task automatic step();
        logic [15:0][15:0] nr = '0, ng = '0;
        bit rdy;
        int c;
        for (int i = 0; i < COLS; i++)
            for (int r = 0; r < ROWS; r++) begin
                nr[ROW_BASE-r][COL_OFS+i] = (mc[i][r] == 0);
                ng[ROW_BASE-r][COL_OFS+i] = (mc[i][r] == 1);
            end
        rdy = (total() < CELLS) && !undo_valid;
        @(posedge clk);
        e_ok = 0; e_rej = 0; e_undo = 0;
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                mh[i] = 0;
                for (int r = 0; r < ROWS; r++) mc[i][r] = -1;
            end
            ml_valid = 0; ml_col = 0; ml_row = 0; nr = '0; ng = '0;
        end else if (undo_valid && ml_valid != 0) begin
            mc[ml_col][ml_row] = -1; mh[ml_col]--; ml_valid = 0; e_undo = 1;
        end else if (drop_valid && rdy) begin
            c = int'(drop_col);
            if (c < COLS && mh[c] < ROWS) begin
                mc[c][mh[c]] = int'(player); ml_col = c; ml_row = mh[c];
                mh[c]++; ml_valid = 1; e_ok = 1;
            end else e_rej = 1;
        end
        er = nr; eg = ng;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; drv(0, 0, 0, 0); step(); reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (heights !== '0) begin miss++; $display("FAIL reset_heights got %h want 0", heights); end
        vec++; if ({move_ok, move_rej, undo_done, last_valid, board_full} !== 5'b0) begin
            miss++; $display("FAIL reset_flags got %b want 00000", {move_ok, move_rej, undo_done, last_valid, board_full}); end
        vec++; if (redpixels !== '0 || grnpixels !== '0) begin
            miss++; $display("FAIL reset_pixels got %h/%h want 0", redpixels, grnpixels); end
        vec++; if (drop_ready !== 1'b1) begin miss++; $display("FAIL reset_ready got %b want 1", drop_ready); end
    endtask

    task automatic test_first_drop();
        drv(1, 2, 0, 0); step(); drv(0, 0, 0, 0);
        vec++; if (move_ok !== 1'b1) begin miss++; $display("FAIL first_ok got %b want 1", move_ok); end
        vec++; if (hcol(2) !== 1) begin miss++; $display("FAIL first_h2 got %0d want 1", hcol(2)); end
        vec++; if ({last_valid, last_col, last_row} !== {1'b1, 4'd2, 3'd0}) begin
            miss++; $display("FAIL first_last got %b/%0d/%0d want 1/2/0", last_valid, last_col, last_row); end
        vec++; if (redpixels[15][6] !== 1'b0) begin miss++; $display("FAIL first_pix_early got %b want 0", redpixels[15][6]); end
        step();
        vec++; if (redpixels[15][6] !== 1'b1) begin miss++; $display("FAIL first_pix got %b want 1", redpixels[15][6]); end
        vec++; if (move_ok !== 1'b0) begin miss++; $display("FAIL first_pulse_width got %b want 0", move_ok); end
    endtask

    task automatic test_full_column();
        do_reset();
        for (int i = 0; i < ROWS; i++) begin drv(1, 0, i[0], 0); step(); end
        step();
        drv(1, 0, 0, 0); step(); drv(0, 0, 0, 0);
        vec++; if ({move_rej, move_ok} !== 2'b10) begin miss++; $display("FAIL col_full_rej got %b want 10", {move_rej, move_ok}); end
        vec++; if (hcol(0) !== 6) begin miss++; $display("FAIL col_full_h0 got %0d want 6", hcol(0)); end
        step();
        vec++; if ({redpixels[10][4], grnpixels[10][4]} !== 2'b01) begin
            miss++; $display("FAIL col_full_pix got %b want 01", {redpixels[10][4], grnpixels[10][4]}); end
    endtask

    task automatic test_out_of_range();
        logic [COLS*RW-1:0] h0 = heights;
        drv(1, 9, 1, 0); step(); drv(0, 0, 0, 0);
        vec++; if (move_rej !== 1'b1) begin miss++; $display("FAIL oor_rej got %b want 1", move_rej); end
        vec++; if (heights !== h0) begin miss++; $display("FAIL oor_heights got %h want %h", heights, h0); end
        vec++; if ({last_valid, last_col, last_row} !== {1'b1, 4'd0, 3'd5}) begin
            miss++; $display("FAIL oor_last got %b/%0d/%0d want 1/0/5", last_valid, last_col, last_row); end
    endtask

    task automatic test_undo();
        do_reset();
        drv(1, 3, 1, 0); step(); drv(0, 0, 0, 0); step();
        vec++; if (grnpixels[15][7] !== 1'b1) begin miss++; $display("FAIL undo_pix_set got %b want 1", grnpixels[15][7]); end
        drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
        vec++; if (undo_done !== 1'b1) begin miss++; $display("FAIL undo_pulse got %b want 1", undo_done); end
        vec++; if (hcol(3) !== 0 || last_valid !== 1'b0) begin
            miss++; $display("FAIL undo_state got h3=%0d lv=%b want 0/0", hcol(3), last_valid); end
        vec++; if (grnpixels[15][7] !== 1'b1) begin miss++; $display("FAIL undo_pix_early got %b want 1", grnpixels[15][7]); end
        step();
        vec++; if (grnpixels[15][7] !== 1'b0) begin miss++; $display("FAIL undo_pix_clr got %b want 0", grnpixels[15][7]); end
        drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
        vec++; if (undo_done !== 1'b0) begin miss++; $display("FAIL undo_second got %b want 0", undo_done); end
    endtask

    task automatic test_priority();
        drv(1, 5, 0, 0); step();
        drv(1, 6, 1, 1);
        vec++; if (drop_ready !== 1'b0) begin miss++; $display("FAIL prio_ready got %b want 0", drop_ready); end
        step();
        vec++; if ({undo_done, move_ok, move_rej} !== 3'b100) begin
            miss++; $display("FAIL prio_undo got %b want 100", {undo_done, move_ok, move_rej}); end
        drv(1, 6, 1, 0);
        vec++; if (drop_ready !== 1'b1) begin miss++; $display("FAIL prio_ready2 got %b want 1", drop_ready); end
        step(); drv(0, 0, 0, 0);
        vec++; if (move_ok !== 1'b1 || hcol(6) !== 1 || hcol(5) !== 0) begin
            miss++; $display("FAIL prio_drop got ok=%b h6=%0d h5=%0d want 1/1/0", move_ok, hcol(6), hcol(5)); end
    endtask

    task automatic test_fill_board();
        do_reset();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin drv(1, c, 1'($urandom), 0); step(); end
        drv(0, 0, 0, 0);
        vec++; if (board_full !== 1'b1 || drop_ready !== 1'b0) begin
            miss++; $display("FAIL fill_full got full=%b rdy=%b want 1/0", board_full, drop_ready); end
        drv(1, 0, 0, 0); step();
        vec++; if ({move_ok, move_rej} !== 2'b00) begin miss++; $display("FAIL fill_drop_ignored got %b want 00", {move_ok, move_rej}); end
        drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
        vec++; if (undo_done !== 1'b1 || board_full !== 1'b0 || hcol(7) !== 5) begin
            miss++; $display("FAIL fill_undo got u=%b full=%b h7=%0d want 1/0/5", undo_done, board_full, hcol(7)); end
        vec++; if (drop_ready !== 1'b1) begin miss++; $display("FAIL fill_play got %b want 1", drop_ready); end
        drv(1, 7, 1, 0); step(); step();
        reset = 1'b1; drv(1, 7, 0, 0); step(); reset = 1'b0; drv(0, 0, 0, 0);
        vec++; if (heights !== '0 || {move_ok, move_rej, undo_done, last_valid, board_full, last_col, last_row} !== '0) begin
            miss++; $display("FAIL midreset_state got h=%h flags=%b want 0", heights, {move_ok, move_rej, undo_done, last_valid, board_full}); end
        vec++; if (redpixels !== '0 || grnpixels !== '0) begin
            miss++; $display("FAIL midreset_pix got %h/%h want 0", redpixels, grnpixels); end
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 2) != 0, $urandom_range(0, 9), 1'($urandom), $urandom_range(0, 6) == 0);
            exp_rdy = (total() < CELLS) && !undo_valid;
            vec++; if (drop_ready !== exp_rdy) begin miss++; $display("FAIL rnd_ready n=%0d got %b want %b", n, drop_ready, exp_rdy); end
            step();
            vec++; if ({move_ok, move_rej, undo_done} !== {e_ok, e_rej, e_undo}) begin
                miss++; $display("FAIL rnd_pulse n=%0d got %b want %b", n, {move_ok, move_rej, undo_done}, {e_ok, e_rej, e_undo}); end
            vec++; if (heights !== exp_h()) begin miss++; $display("FAIL rnd_heights n=%0d got %h want %h", n, heights, exp_h()); end
            vec++; if (last_valid !== 1'(ml_valid) || (ml_valid != 0 && (last_col !== 4'(ml_col) || last_row !== 3'(ml_row)))) begin
                miss++; $display("FAIL rnd_last n=%0d got %b/%0d/%0d want %0d/%0d/%0d", n, last_valid, last_col, last_row, ml_valid, ml_col, ml_row); end
            vec++; if (board_full !== (total() == CELLS)) begin miss++; $display("FAIL rnd_full n=%0d got %b", n, board_full); end
            vec++; if (redpixels !== er || grnpixels !== eg) begin
                miss++; $display("FAIL rnd_pix n=%0d got %h/%h want %h/%h", n, redpixels, grnpixels, er, eg); end
        end
        drv(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_first_drop();
        test_full_column();
        test_out_of_range();
        test_undo();
        test_priority();
        test_fill_board();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
